cpci_reg_bridge: RTL and testbench

Single-clock, parametrised successor to the CPCI register-bus front end. Host-side level request/ready handshake is funnelled through a configurable-depth request FIFO to the internal register bus. One read may be outstanding at a time. A new read-timeout watchdog returns a fixed pattern so a missing bus_rd_vld can never hang the host. Sits between the CPCI pin interface and the register-group decoder, all in clk domain.

---
 rtl/cpci_reg_bridge_pkg.sv | 18 +
 rtl/cpci_reg_bridge_reg_req_fifo.sv | 57 +++++
 rtl/cpci_reg_bridge.sv | 195 +++++++++++++++++++
 tb/tb_cpci_reg_bridge.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpci_reg_bridge_pkg.sv
// Shared types and constants for the CPCI register bridge: FSM state encoding,
// default timeout read pattern and request FIFO entry width.
package cpci_reg_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_READING = 2'd1,
      ST_RD_DONE = 2'd2
   } state_e;

   localparam logic [31:0] TIMEOUT_DATA_DFLT = 32'hDEAD_0BAD;

   // Entry layout, MSB first: {rd_wr_L, addr, wr_data}
   function automatic int entry_width(input int addr_w, input int data_w);
      return 1 + addr_w + data_w;
   endfunction

endpackage

// File: rtl/cpci_reg_bridge_reg_req_fifo.sv
// Single-clock show-ahead request FIFO; the extra pointer bit separates full
// from empty when the wrapped pointers are equal.
module reg_req_fifo
   import cpci_reg_bridge_pkg::*;
#(
   parameter int  WIDTH = 60,
   parameter int  DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push;
   logic             do_pop;

   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign count = wr_ptr_q - rd_ptr_q;
   assign head_data = mem_q[rd_ptr_q[AW-1:0]];

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: nothing reads it while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/cpci_reg_bridge.sv
// CPCI host to internal register bus bridge with request FIFO and read watchdog.
// Optional statistics counters are enabled by defining CPCI_REG_BRIDGE_STATS_EN.
module cpci_reg_bridge
   import cpci_reg_bridge_pkg::*;
#(
   parameter int                    ADDR_WIDTH       = 27,
   parameter int                    DATA_WIDTH       = 32,
   parameter int                    FIFO_DEPTH       = 16,
   parameter int                    PROG_FULL_THRESH = 12,
   parameter int                    RD_TIMEOUT       = 1024,
   parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA     = DATA_WIDTH'(TIMEOUT_DATA_DFLT)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  host_req,
   input  logic                  host_rd_wr_L,
   input  logic [ADDR_WIDTH-1:0] host_addr,
   input  logic [DATA_WIDTH-1:0] host_wr_data,
   output logic [DATA_WIDTH-1:0] host_rd_data,
   output logic                  host_data_tri_en,
   output logic                  host_rd_rdy,
   output logic                  host_wr_rdy,
   output logic                  bus_req,
   input  logic                  bus_ack,
   output logic                  bus_rd_wr_L,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [DATA_WIDTH-1:0] bus_wr_data,
   input  logic [DATA_WIDTH-1:0] bus_rd_data,
   input  logic                  bus_rd_vld,
   output logic                  rd_timeout,
   output logic                  rd_spurious
`ifdef CPCI_REG_BRIDGE_STATS_EN
   ,
   output logic [31:0]           stat_wr_cnt,
   output logic [31:0]           stat_rd_cnt,
   output logic [31:0]           stat_timeout_cnt
`endif
);

   localparam int EW = entry_width(ADDR_WIDTH, DATA_WIDTH);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int TW = $clog2(RD_TIMEOUT);

   // Handshake: the host holds host_req as a level; a write is taken on every
   // cycle it is seen in IDLE with FIFO space, a read once, after which the host
   // keeps host_req high until host_rd_rdy and then drops it. bus_req is a valid
   // for the FIFO head and bus_ack is its ready; an ack with no head is ignored.
   logic                  h_req_q;
   logic                  h_rd_wr_l_q;
   logic [ADDR_WIDTH-1:0] h_addr_q;
   logic [DATA_WIDTH-1:0] h_wr_data_q;

   state_e                state_q, state_d;
   logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_rdy_q, rd_rdy_d;
   logic                  tmo_pulse_q, tmo_pulse_d;
   logic                  spur_q, spur_d;
   logic                  wr_rdy_q, wr_rdy_d;

   logic                  push;
   logic [EW-1:0]         head;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [CW-1:0]         fifo_count;

   reg_req_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (reset_n),
      .push      (push),
      .push_data ({h_rd_wr_l_q, h_addr_q, h_wr_data_q}),
      .pop       (bus_ack),
      .head_data (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      state_d     = state_q;
      tmo_cnt_d   = tmo_cnt_q;
      rd_data_d   = rd_data_q;
      rd_rdy_d    = 1'b0;
      tmo_pulse_d = 1'b0;
      push        = 1'b0;
      spur_d      = bus_rd_vld && (state_q != ST_READING);
      wr_rdy_d    = (fifo_count < CW'(PROG_FULL_THRESH));
      unique case (state_q)
         ST_IDLE: begin
            if (h_req_q && !fifo_full) begin
               push = 1'b1;
               if (h_rd_wr_l_q) begin
                  state_d   = ST_READING;
                  tmo_cnt_d = '0;
               end
            end
         end
         ST_READING: begin
            // A return in the same cycle as the deadline still counts as data.
            if (bus_rd_vld) begin
               rd_data_d = bus_rd_data;
               rd_rdy_d  = 1'b1;
               state_d   = ST_RD_DONE;
            end else if (tmo_cnt_q == TW'(RD_TIMEOUT - 1)) begin
               rd_data_d   = TIMEOUT_DATA;
               rd_rdy_d    = 1'b1;
               tmo_pulse_d = 1'b1;
               state_d     = ST_RD_DONE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
         end
         ST_RD_DONE: begin
            if (!h_req_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h_req_q     <= 1'b0;
         h_rd_wr_l_q <= 1'b0;
         h_addr_q    <= '0;
         h_wr_data_q <= '0;
         state_q     <= ST_IDLE;
         tmo_cnt_q   <= '0;
         rd_data_q   <= '0;
         rd_rdy_q    <= 1'b0;
         tmo_pulse_q <= 1'b0;
         spur_q      <= 1'b0;
         wr_rdy_q    <= 1'b0;
      end else begin
         h_req_q     <= host_req;
         h_rd_wr_l_q <= host_rd_wr_L;
         h_addr_q    <= host_addr;
         h_wr_data_q <= host_wr_data;
         state_q     <= state_d;
         tmo_cnt_q   <= tmo_cnt_d;
         rd_data_q   <= rd_data_d;
         rd_rdy_q    <= rd_rdy_d;
         tmo_pulse_q <= tmo_pulse_d;
         spur_q      <= spur_d;
         wr_rdy_q    <= wr_rdy_d;
      end
   end

   assign host_rd_data     = rd_data_q;
   assign host_rd_rdy      = rd_rdy_q;
   assign host_data_tri_en = rd_rdy_q;
   assign host_wr_rdy      = wr_rdy_q;
   assign rd_timeout       = tmo_pulse_q;
   assign rd_spurious      = spur_q;

   // Head fields are forced to zero when empty so stale storage never shows.
   assign bus_req     = !fifo_empty;
   assign bus_rd_wr_L = fifo_empty ? 1'b0 : head[EW-1];
   assign bus_addr    = fifo_empty ? '0 : head[EW-2 -: ADDR_WIDTH];
   assign bus_wr_data = fifo_empty ? '0 : head[DATA_WIDTH-1:0];

`ifdef CPCI_REG_BRIDGE_STATS_EN
   logic [31:0] stat_wr_q, stat_wr_d;
   logic [31:0] stat_rd_q, stat_rd_d;
   logic [31:0] stat_to_q, stat_to_d;

   always_comb begin
      stat_wr_d = stat_wr_q;
      stat_rd_d = stat_rd_q;
      stat_to_d = stat_to_q;
      if (push && !h_rd_wr_l_q && (stat_wr_q != '1)) stat_wr_d = stat_wr_q + 32'd1;
      if (push && h_rd_wr_l_q && (stat_rd_q != '1))  stat_rd_d = stat_rd_q + 32'd1;
      if (tmo_pulse_d && (stat_to_q != '1))          stat_to_d = stat_to_q + 32'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_wr_q <= '0;
         stat_rd_q <= '0;
         stat_to_q <= '0;
      end else begin
         stat_wr_q <= stat_wr_d;
         stat_rd_q <= stat_rd_d;
         stat_to_q <= stat_to_d;
      end
   end

   assign stat_wr_cnt      = stat_wr_q;
   assign stat_rd_cnt      = stat_rd_q;
   assign stat_timeout_cnt = stat_to_q;
`endif

endmodule

// File: tb/tb_cpci_reg_bridge.sv
// Self-checking bench for cpci_reg_bridge: directed scenarios plus randomized
// host/bus traffic against a transaction-level reference model.
module tb_cpci_reg_bridge;

   localparam int          AW       = 27;
   localparam int          DW       = 32;
   localparam int          DEPTH    = 16;
   localparam int          THRESH   = 12;
   localparam int          TMO      = 8;
   localparam int          EW       = 1 + AW + DW;
   localparam logic [31:0] TMO_DATA = 32'hDEAD_0BAD;

   // clock / reset
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic          host_req = 1'b0;
   logic          host_rd_wr_L = 1'b0;
   logic [AW-1:0] host_addr = '0;
   logic [DW-1:0] host_wr_data = '0;
   logic [DW-1:0] host_rd_data;
   logic          host_data_tri_en;
   logic          host_rd_rdy;
   logic          host_wr_rdy;
   logic          bus_req;
   logic          bus_ack = 1'b0;
   logic          bus_rd_wr_L;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wr_data;
   logic [DW-1:0] bus_rd_data = '0;
   logic          bus_rd_vld = 1'b0;
   logic          rd_timeout;
   logic          rd_spurious;
`ifdef CPCI_REG_BRIDGE_STATS_EN
   logic [31:0]   stat_wr_cnt;
   logic [31:0]   stat_rd_cnt;
   logic [31:0]   stat_timeout_cnt;
`endif

   cpci_reg_bridge #(
      .ADDR_WIDTH       (AW),
      .DATA_WIDTH       (DW),
      .FIFO_DEPTH       (DEPTH),
      .PROG_FULL_THRESH (THRESH),
      .RD_TIMEOUT       (TMO),
      .TIMEOUT_DATA     (TMO_DATA)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .host_req         (host_req),
      .host_rd_wr_L     (host_rd_wr_L),
      .host_addr        (host_addr),
      .host_wr_data     (host_wr_data),
      .host_rd_data     (host_rd_data),
      .host_data_tri_en (host_data_tri_en),
      .host_rd_rdy      (host_rd_rdy),
      .host_wr_rdy      (host_wr_rdy),
      .bus_req          (bus_req),
      .bus_ack          (bus_ack),
      .bus_rd_wr_L      (bus_rd_wr_L),
      .bus_addr         (bus_addr),
      .bus_wr_data      (bus_wr_data),
      .bus_rd_data      (bus_rd_data),
      .bus_rd_vld       (bus_rd_vld),
      .rd_timeout       (rd_timeout),
      .rd_spurious      (rd_spurious)
`ifdef CPCI_REG_BRIDGE_STATS_EN
      ,
      .stat_wr_cnt      (stat_wr_cnt),
      .stat_rd_cnt      (stat_rd_cnt),
      .stat_timeout_cnt (stat_timeout_cnt)
`endif
   );

   // scoreboard / reference model state
   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;
   logic [EW-1:0] exp_q[$];
   int            rdy_q[$];
   int            prev_occ = 0;
   int            ack_mode = 0;
   int            exp_rdy_cyc = -1;
   int            exp_spur_cyc = -1;
   bit            exp_to = 1'b0;
   logic [31:0]   exp_rd_data = '0;
   bit            read_active = 1'b0;
   bit            ret_pending = 1'b0;
   int            ret_cyc = 0;
   logic [31:0]   ret_data = '0;
   int            cur_ret_delay = -1;
   logic [31:0]   cur_ret_data = '0;
   int            n_wr = 0;
   int            n_rd = 0;
   int            n_to = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   function automatic bit rd_in_q();
      foreach (exp_q[i]) if (exp_q[i][EW-1]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      rdy_q.delete();
      prev_occ     = 0;
      exp_rdy_cyc  = -1;
      exp_spur_cyc = -1;
      read_active  = 1'b0;
      ret_pending  = 1'b0;
      n_wr = 0;
      n_rd = 0;
      n_to = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_rd_data"}, host_rd_data, 0);
      check_eq({tag, "_tri_en"}, host_data_tri_en, 0);
      check_eq({tag, "_rd_rdy"}, host_rd_rdy, 0);
      check_eq({tag, "_wr_rdy"}, host_wr_rdy, 0);
      check_eq({tag, "_bus_req"}, bus_req, 0);
      check_eq({tag, "_bus_rdwr"}, bus_rd_wr_L, 0);
      check_eq({tag, "_bus_addr"}, bus_addr, 0);
      check_eq({tag, "_bus_wdata"}, bus_wr_data, 0);
      check_eq({tag, "_rd_timeout"}, rd_timeout, 0);
      check_eq({tag, "_rd_spurious"}, rd_spurious, 0);
   endtask

   // One clock: check outputs at the falling edge, then drive bus-side inputs.
   task automatic tick();
      int            occ;
      bit            do_ack;
      logic [EW-1:0] head;
      @(negedge clk);
      cyc++;
      occ = 0;
      foreach (rdy_q[i]) if (rdy_q[i] <= cyc) occ++;
      check_eq("bus_req", bus_req, occ != 0);
      check_eq("host_wr_rdy", host_wr_rdy, prev_occ < THRESH);
      prev_occ = occ;
      check_eq("host_rd_rdy", host_rd_rdy, cyc == exp_rdy_cyc);
      check_eq("host_tri_en", host_data_tri_en, cyc == exp_rdy_cyc);
      check_eq("rd_timeout", rd_timeout, (cyc == exp_rdy_cyc) && exp_to);
      check_eq("rd_spurious", rd_spurious, cyc == exp_spur_cyc);
      if (cyc == exp_rdy_cyc) begin
         check_eq("host_rd_data", host_rd_data, exp_rd_data);
         if (exp_to) n_to++;
         read_active = 1'b0;
      end
      bus_rd_vld = 1'b0;
      if (ret_pending && cyc == ret_cyc) begin
         bus_rd_vld  = 1'b1;
         bus_rd_data = ret_data;
         ret_pending = 1'b0;
         if (read_active && (cyc + 1 <= exp_rdy_cyc)) begin
            exp_rdy_cyc = cyc + 1;
            exp_to      = 1'b0;
            exp_rd_data = ret_data;
         end else begin
            exp_spur_cyc = cyc + 1;
         end
      end
      do_ack  = (ack_mode == 1) || ((ack_mode == 2) && ($urandom_range(0, 1) == 1));
      bus_ack = do_ack;
      if (do_ack && occ != 0) begin
         head = exp_q.pop_front();
         void'(rdy_q.pop_front());
         check_eq("bus_rd_wr_L", bus_rd_wr_L, head[EW-1]);
         check_eq("bus_addr", bus_addr, head[EW-2 -: AW]);
         check_eq("bus_wr_data", bus_wr_data, head[DW-1:0]);
         if (head[EW-1] && cur_ret_delay >= 0) begin
            ret_pending = 1'b1;
            ret_cyc     = cyc + 1 + cur_ret_delay;
            ret_data    = cur_ret_data;
         end
      end
   endtask

   // driver tasks
   task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
      host_req     = 1'b1;
      host_rd_wr_L = 1'b0;
      host_addr    = addr;
      host_wr_data = data;
      exp_q.push_back({1'b0, addr, data});
      rdy_q.push_back(cyc + 2);
      n_wr++;
      tick();
      host_req = 1'b0;
   endtask

   task automatic do_write_paced();
      int n = 0;
      while (!host_wr_rdy && n < 100) begin
         tick();
         n++;
      end
      check_eq("wr_rdy_wait", n < 100, 1);
      do_write(AW'($urandom), $urandom);
   endtask

   task automatic do_read(input logic [AW-1:0] addr, input int delay, input logic [31:0] data,
                          input int hold);
      int n;
      int saved_ack = ack_mode;
      ack_mode      = 1;
      host_req      = 1'b1;
      host_rd_wr_L  = 1'b1;
      host_addr     = addr;
      host_wr_data  = $urandom;
      exp_q.push_back({1'b1, addr, host_wr_data});
      rdy_q.push_back(cyc + 2);
      n_rd++;
      read_active   = 1'b1;
      exp_rdy_cyc   = cyc + 2 + TMO;
      exp_to        = 1'b1;
      exp_rd_data   = TMO_DATA;
      cur_ret_delay = delay;
      cur_ret_data  = data;
      n = 0;
      while (read_active && n < 100) begin
         tick();
         n++;
      end
      check_eq("read_done", read_active, 0);
      repeat (hold) tick();
      host_req = 1'b0;
      n = 0;
      while ((ret_pending || rd_in_q()) && n < 200) begin
         tick();
         n++;
      end
      repeat (2) tick();
      ack_mode = saved_ack;
   endtask

   task automatic stray_vld();
      ret_pending = 1'b1;
      ret_cyc     = cyc + 1;
      ret_data    = $urandom;
      repeat (3) tick();
   endtask

   task automatic check_stats(input string tag);
`ifdef CPCI_REG_BRIDGE_STATS_EN
      check_eq({tag, "_stat_wr"}, stat_wr_cnt, n_wr);
      check_eq({tag, "_stat_rd"}, stat_rd_cnt, n_rd);
      check_eq({tag, "_stat_to"}, stat_timeout_cnt, n_to);
`else
      if (tag.len() == 0) $display("stats disabled");
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "bench timed out");
   end

   initial begin
      int n;
      // reset state
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset_n = 1'b1;
      model_reset();
      repeat (2) tick();

      // single write, acked two cycles after bus_req rises
      ack_mode = 0;
      do_write(27'h10, 32'hA5A5_A5A5);
      tick();
      tick();
      ack_mode = 1;
      tick();
      ack_mode = 0;
      repeat (2) tick();

      // read returning 0x12345678 three cycles after pop, host holds req longer
      do_read(27'h20, 3, 32'h1234_5678, 3);

      // no return: timeout pattern, then a stray return is flagged
      do_read(27'h30, -1, 32'h0, 1);
      stray_vld();

      // return exactly at the deadline wins; one cycle later is a timeout
      do_read(27'h40, TMO - 2, 32'hCAFE_F00D, 0);
      do_read(27'h50, TMO - 1, 32'h0BAD_CAFE, 0);

      // 16 back-to-back writes with no acks, then a blocked 17th
      ack_mode = 0;
      for (int i = 0; i < 16; i++) do_write(AW'(27'h100 + i), $urandom);
      host_req     = 1'b1;
      host_rd_wr_L = 1'b0;
      host_addr    = 27'h1FF;
      host_wr_data = 32'hFFFF_0000;
      repeat (6) tick();
      host_req = 1'b0;
      repeat (2) tick();
      ack_mode = 1;
      n = 0;
      while (rdy_q.size() > 0 && n < 100) begin
         tick();
         n++;
      end
      check_eq("stress_drain", rdy_q.size(), 0);
      repeat (3) tick();

      // randomized traffic
      ack_mode = 2;
      for (int it = 0; it < 40; it++) begin
         int sel = $urandom_range(0, 9);
         if (sel <= 5) begin
            int len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
               do_write_paced();
               repeat ($urandom_range(0, 2)) tick();
            end
         end else if (sel <= 8) begin
            int d = $urandom_range(0, 11);
            do_read(AW'($urandom), (d == 11) ? -1 : d, $urandom, $urandom_range(0, 2));
         end else if (!ret_pending) begin
            stray_vld();
         end
      end
      ack_mode = 1;
      n = 0;
      while (rdy_q.size() > 0 && n < 100) begin
         tick();
         n++;
      end
      repeat (2) tick();
      check_stats("run");

      // reset while a read is outstanding with three entries queued
      ack_mode = 0;
      do_write(27'h200, $urandom);
      do_write(27'h201, $urandom);
      host_req     = 1'b1;
      host_rd_wr_L = 1'b1;
      host_addr    = 27'h202;
      repeat (4) tick();
      reset_n = 1'b0;
      #1;
      check_reset_outputs("midrd");
      host_req   = 1'b0;
      bus_ack    = 1'b0;
      bus_rd_vld = 1'b0;
      @(posedge clk);
      #1;
      check_eq("midrd_hold_bus_req", bus_req, 0);
      check_eq("midrd_hold_rd_rdy", host_rd_rdy, 0);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      repeat (2) tick();
      do_read(27'h155, 2, 32'h5A5A_1234, 0);
      check_stats("post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
